grant_servicer: RTL and testbench

GRANT_SERVICER -- requirements
Module: grant_servicer

---
 rtl/grant_servicer_if.sv | 25 ++
 rtl/grant_servicer.sv | 116 +++++++++++
 tb/tb_grant_servicer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/grant_servicer_if.sv
// Handshake bundle between the round-robin arbiter (master) and the grant servicer (slave).
interface grant_servicer_if #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
);
  logic [WIDTH-1:0] grant;
  logic [LEN_W-1:0] req_len;
  logic             beat_ready;
  logic             beat_valid;
  logic [WIDTH-1:0] owner;
  logic [LEN_W-1:0] beat_cnt;
  logic             ack;
  logic             busy;
  logic             err;

  modport master (
    output grant, req_len, beat_ready,
    input  beat_valid, owner, beat_cnt, ack, busy, err
  );

  modport slave (
    input  grant, req_len, beat_ready,
    output beat_valid, owner, beat_cnt, ack, busy, err
  );
endinterface

// File: rtl/grant_servicer.sv
// Services one arbiter grant as a burst of beats, then acks the arbiter.
// Define GS_TIMEOUT_EN to add a stall watchdog that aborts a stuck burst after TIMEOUT cycles.
module grant_servicer #(
  parameter int WIDTH   = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  grant_servicer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_ACK} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_owner;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_err;

  logic             w_onehot;
  logic             w_illegal;
  logic             w_accept;
  logic             w_last;
  logic             w_tmo;
  logic [LEN_W-1:0] w_len_eff;

  assign w_onehot  = (bus.grant != '0) && ((bus.grant & (bus.grant - 1'b1)) == '0);
  assign w_illegal = (r_state == S_IDLE) && (bus.grant != '0) && !w_onehot;
  assign w_accept  = (r_state == S_XFER) && bus.beat_ready;
  assign w_last    = w_accept && ((r_cnt + 1'b1) == r_len);
  // A zero-length request still moves one beat.
  assign w_len_eff = (bus.req_len == '0) ? LEN_W'(1) : bus.req_len;

`ifdef GS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wdog;
  logic          w_stall;

  assign w_stall = (r_state == S_XFER) && !bus.beat_ready;
  // Abort on the edge that would bring the stall count up to TIMEOUT.
  assign w_tmo   = w_stall && (r_wdog == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_wdog <= '0;
    else if (w_stall)  r_wdog <= r_wdog + 1'b1;
    else               r_wdog <= '0;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_onehot) w_next = S_XFER;
      S_XFER:  if (w_last || w_tmo) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.beat_valid = 1'b0;
    bus.ack        = 1'b0;
    bus.busy       = 1'b0;
    case (r_state)
      S_XFER: begin
        bus.beat_valid = 1'b1;
        bus.busy       = 1'b1;
      end
      S_ACK: begin
        bus.ack  = 1'b1;
        bus.busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Burst context: latched only in IDLE, held through XFER, dropped when ACK retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_illegal || w_tmo;
      case (r_state)
        S_IDLE: if (w_onehot) begin
          r_owner <= bus.grant;
          r_len   <= w_len_eff;
          r_cnt   <= '0;
        end
        S_XFER: if (w_accept) r_cnt <= r_cnt + 1'b1;
        S_ACK: begin
          r_owner <= '0;
          r_len   <= '0;
          r_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.owner    = r_owner;
  assign bus.beat_cnt = r_cnt;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_grant_servicer.sv
// Randomized bench for grant_servicer against a burst-level reference model.
module tb_grant_servicer;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  grant_servicer_if #(.WIDTH(4), .LEN_W(4)) bus ();

  grant_servicer #(.WIDTH(4), .LEN_W(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"},  32'(bus.busy), 0);
    check_eq({tag, "_valid"}, 32'(bus.beat_valid), 0);
    check_eq({tag, "_ack"},   32'(bus.ack), 0);
    check_eq({tag, "_owner"}, 32'(bus.owner), 0);
    check_eq({tag, "_cnt"},   32'(bus.beat_cnt), 0);
  endtask

  // Presents grant g with length len in the current IDLE cycle and follows the burst to IDLE.
  // Ready comes from pat (first pat_n XFER cycles, then 1) or is random with bounded stalls.
  task automatic do_burst(input logic [3:0] g, input int len, input logic [31:0] pat,
                          input int pat_n, output int n_xfer);
    int   eff, beats, cyc, stall;
    logic r;
    eff = (len == 0) ? 1 : len;
    check_eq("pre_busy", 32'(bus.busy), 0);
    bus.grant      = g;
    bus.req_len    = 4'(len);
    bus.beat_ready = 1'($urandom_range(0, 1));
    tick();
    beats = 0;
    cyc   = 0;
    stall = 0;
    while (beats < eff && cyc < 200) begin
      check_eq("xfer_valid", 32'(bus.beat_valid), 1);
      check_eq("xfer_busy",  32'(bus.busy), 1);
      check_eq("xfer_owner", 32'(bus.owner), 32'(g));
      check_eq("xfer_cnt",   32'(bus.beat_cnt), 32'(beats));
      check_eq("xfer_ack",   32'(bus.ack), 0);
      check_eq("xfer_err",   32'(bus.err), 0);
      bus.grant   = 4'($urandom);
      bus.req_len = 4'($urandom);
      if (pat_n > 0) r = (cyc < pat_n) ? pat[cyc] : 1'b1;
      else begin
        r = ($urandom_range(0, 2) != 0);
        if (stall >= 3) r = 1'b1;
      end
      stall = r ? 0 : stall + 1;
      bus.beat_ready = r;
      tick();
      if (r) beats++;
      cyc++;
    end
    check_eq("xfer_bound", 32'(cyc < 200), 1);
    n_xfer = cyc;
    check_eq("ack_pulse", 32'(bus.ack), 1);
    check_eq("ack_valid", 32'(bus.beat_valid), 0);
    check_eq("ack_cnt",   32'(bus.beat_cnt), 32'(eff));
    check_eq("ack_owner", 32'(bus.owner), 32'(g));
    check_eq("ack_busy",  32'(bus.busy), 1);
    check_eq("ack_err",   32'(bus.err), 0);
    bus.grant      = 4'($urandom);
    bus.beat_ready = 1'($urandom_range(0, 1));
    tick();
    check_idle("post");
    check_eq("post_err", 32'(bus.err), 0);
    bus.grant = '0;
  endtask

  task automatic illegal_grant(input logic [3:0] g);
    bus.grant = g;
    tick();
    check_eq("ill_err",   32'(bus.err), 1);
    check_eq("ill_busy",  32'(bus.busy), 0);
    check_eq("ill_owner", 32'(bus.owner), 0);
    check_eq("ill_valid", 32'(bus.beat_valid), 0);
    bus.grant = '0;
    tick();
    check_eq("ill_err_clr", 32'(bus.err), 0);
    check_eq("ill_idle",    32'(bus.busy), 0);
  endtask

  initial begin
    int          nx;
    int          n_ack, n_err, ack_at;
    logic [3:0]  g;
    logic [31:0] ones;
    ones = '1;
    rst            = 1'b1;
    bus.grant      = '0;
    bus.req_len    = '0;
    bus.beat_ready = 1'b0;
    #12;
    check_idle("rst");
    check_eq("rst_err", 32'(bus.err), 0);
    @(negedge clk);
    rst = 1'b0;

    // First grant sampled in the first IDLE cycle after reset
    do_burst(4'b0100, 3, ones, 3, nx);
    check_eq("single_xfer_cycles", 32'(nx), 3);

    do_burst(4'b0001, 2, 32'b10010, 5, nx);
    check_eq("bp_xfer_cycles", 32'(nx), 5);

    illegal_grant(4'b0110);
    do_burst(4'b0010, 2, 0, 0, nx);

    do_burst(4'b0001, 0, ones, 4, nx);
    check_eq("zero_len_cycles", 32'(nx), 1);
    do_burst(4'b1000, 1, ones, 1, nx);
    check_eq("b2b_cycles", 32'(nx), 1);

    do_burst(4'b0100, 15, ones, 20, nx);
    check_eq("max_len_cycles", 32'(nx), 15);

    // Asynchronous reset mid-burst
    bus.grant = 4'b0001; bus.req_len = 4'd5; bus.beat_ready = 1'b1;
    tick();
    bus.grant = '0;
    tick();
    tick();
    check_eq("mid_cnt", 32'(bus.beat_cnt), 2);
    #2 rst = 1'b1;
    #1;
    check_idle("abort");
    check_eq("abort_err", 32'(bus.err), 0);
    tick();
    check_idle("abort_hold");
    #2 rst = 1'b0;
    bus.beat_ready = 1'b0;
    tick();
    check_idle("after_rst");
    do_burst(4'b0010, 3, 0, 0, nx);

    // Ready held low for a long time
    bus.grant = 4'b0001; bus.req_len = 4'd4; bus.beat_ready = 1'b0;
    tick();
    bus.grant = '0;
    n_ack = 0; n_err = 0; ack_at = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.ack) begin
        n_ack++;
        if (ack_at < 0) begin
          ack_at = i;
          check_eq("tmo_cnt_at_ack", 32'(bus.beat_cnt), 0);
          check_eq("tmo_err_at_ack", 32'(bus.err), 1);
        end
      end
      if (bus.err) n_err++;
    end
`ifdef GS_TIMEOUT_EN
    check_eq("tmo_ack_cycle", 32'(ack_at), 16);
    check_eq("tmo_n_ack", 32'(n_ack), 1);
    check_eq("tmo_n_err", 32'(n_err), 1);
    check_eq("tmo_idle", 32'(bus.busy), 0);
`else
    check_eq("stall_n_ack", 32'(n_ack), 0);
    check_eq("stall_n_err", 32'(n_err), 0);
    check_eq("stall_busy", 32'(bus.busy), 1);
    check_eq("stall_valid", 32'(bus.beat_valid), 1);
`endif
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    tick();
    check_idle("recover");

    // Random mix of bursts, illegal grants and idle gaps
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0: begin
          do g = 4'($urandom); while ($countones(g) < 2);
          illegal_grant(g);
        end
        1: begin
          bus.grant = '0;
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            bus.beat_ready = 1'($urandom_range(0, 1));
            tick();
            check_eq("gap_busy", 32'(bus.busy), 0);
            check_eq("gap_err",  32'(bus.err), 0);
          end
        end
        default: begin
          g = 4'(1 << $urandom_range(0, 3));
          do_burst(g, int'($urandom_range(0, 15)), 0, 0, nx);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
